wrapper_uart_rx: RTL and testbench
==================================

// Module: wrapper_uart_rx
// PURPOSE
// - Top-level UART receive wrapper: turns the asynchronous serial line from the board's
//   USB-UART bridge into 8-bit parallel symbols plus a one-cycle "new symbol" strobe.
// - Frame format: 8N1 (1 start, 8 data LSB first, 1 stop), idle-high line.
// - Sits between the board pin and downstream symbol consumers (FIFO/decoder).
// PARAMETERS
// - CLK_FREQ_HZ  100_000_000  system clock frequency (10 ns period)
// - BAUD_RATE    115_200      serial bit rate
// - CLKS_PER_BIT (localparam) = CLK_FREQ_HZ/BAUD_RATE, integer division (868 at defaults)
// PORTS
// - clk           in   1  system clock, rising edge
// - rst_n         in   1  reset, asynchronous, active-low
// - uart_rxd_out  in   1  serial line (named from the bridge's view: bridge output, FPGA input)
// - symbol_o      out  8  last correctly received data byte
// - newSymbol_o   out  1  one-cycle strobe: symbol_o just updated
// BEHAVIOUR
// - Interface: single clock domain clk; rst_n is asynchronous, active-low.
// - Input sync: 2-FF synchronizer on uart_rxd_out, both stages reset to 1 (idle). All logic uses
//   the synchronized line (rxd_s).
// - Reset values: symbol_o=8'h00, newSymbol_o=0, FSM=IDLE, counters=0. Reset is honoured at any
//   point mid-frame: the partial frame is discarded, no strobe.
// - FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
//   IDLE: rxd_s==0 -> START, clear bit counter (clk_cnt=0).
//   START: at clk_cnt==CLKS_PER_BIT/2-1 (mid start bit) sample. 0 -> DATA, clk_cnt=0, bit_idx=0.
//     1 -> glitch/false start -> IDLE.
//   DATA: every CLKS_PER_BIT clocks sample rxd_s into shift reg bit[bit_idx], LSB first.
//     After bit_idx==7 -> STOP.
//   STOP: after CLKS_PER_BIT clocks sample. 1 -> symbol_o<=shift reg, newSymbol_o<=1 for exactly
//     one cycle, -> IDLE. 0 -> framing error: symbol_o unchanged, no strobe, -> WAIT_IDLE.
//   WAIT_IDLE: stay until rxd_s==1, then -> IDLE (prevents a break condition from re-triggering).
// - Latency: strobe asserts ~9.5 bit times + 2 sync cycles (+1 register) after the start-bit falling edge.
// - symbol_o holds its value between frames; newSymbol_o is high only in the cycle after capture.
// - Back-to-back frames: a start bit directly after the stop-bit sample is accepted (IDLE is
//   re-entered mid stop bit, so no gap is required).
// - Counters: clk_cnt sized $clog2(CLKS_PER_BIT)+1, wraps to 0 on each bit boundary;
//   bit_idx is 3 bits.
// CONFIGURATION
// - Macro UART_RX_PARITY_EN:
//   defined -> frame is 8E1. A parity state sits between DATA and STOP and samples the even-parity
//     bit. Extra output parityErr_o (1 bit, reset 0) is a one-cycle strobe on mismatch.
//     On mismatch: no newSymbol_o, symbol_o unchanged.
//   undefined -> 8N1 as above; no parity state, no parityErr_o port.
// TESTING
// - Sim params CLK_FREQ_HZ=100e6, BAUD_RATE=10e6 (10 clks/bit); hold line at 1 after reset.
// - Reset: rst_n=0 for 3 cycles -> symbol_o==8'h00, newSymbol_o==0, no strobe while line idles.
// - Send 8'hA5 (8N1) -> exactly one newSymbol_o pulse, 1 cycle wide; symbol_o==8'hA5 and holds.
// - Back-to-back 8'h00, 8'hFF, 8'h3C -> three strobes, symbol_o sequence 00, FF, 3C.
// - 3-clock low glitch on idle line -> no strobe, FSM back in IDLE; next frame 8'h5A received.
// - Frame 8'h81 with stop bit forced 0, line held low 20 bit times, then high -> no strobe,
//   symbol_o keeps previous value; following frame 8'h42 received correctly.
// - rst_n pulsed mid-data of frame 8'hC3 -> outputs go to reset values immediately; no strobe for
//   that frame; next full frame 8'h11 received.

Source files
------------

// File: rtl/wrapper_uart_rx.sv
// wrapper_uart_rx: UART receiver for the board's USB-UART bridge line.
// Default frame is 8N1 (start, 8 data bits LSB first, stop) on an idle-high line.
// Optional feature macro UART_RX_PARITY_EN switches the frame to 8E1.
// That build adds an even-parity check between the data and stop bits and a parityErr_o strobe.
// Each good frame updates symbol_o and pulses newSymbol_o for one cycle.
module wrapper_uart_rx #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd_out,
  output logic [7:0] symbol_o,
  output logic       newSymbol_o
`ifdef UART_RX_PARITY_EN
  ,output logic      parityErr_o
`endif
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY    = 3'd5,
`endif
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

`ifdef UART_RX_PARITY_EN
  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction
`endif

  logic             rxd_meta_r;
  logic             rxd_s;
  state_t           state_r,   state_nxt;
  logic [CNT_W-1:0] clk_cnt_r, clk_cnt_nxt;
  logic [2:0]       bit_idx_r, bit_idx_nxt;
  logic [7:0]       shift_r,   shift_nxt;
  logic [7:0]       symbol_r,  symbol_nxt;
  logic             new_sym_r, new_sym_nxt;
`ifdef UART_RX_PARITY_EN
  logic             perr_r,    perr_nxt;
`endif

  // Two-flop synchronizer; both stages idle high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta_r <= 1'b1;
      rxd_s      <= 1'b1;
    end else begin
      rxd_meta_r <= uart_rxd_out;
      rxd_s      <= rxd_meta_r;
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      clk_cnt_r <= CNT_ZERO;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      symbol_r  <= 8'h00;
      new_sym_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_r    <= 1'b0;
`endif
    end else begin
      state_r   <= state_nxt;
      clk_cnt_r <= clk_cnt_nxt;
      bit_idx_r <= bit_idx_nxt;
      shift_r   <= shift_nxt;
      symbol_r  <= symbol_nxt;
      new_sym_r <= new_sym_nxt;
`ifdef UART_RX_PARITY_EN
      perr_r    <= perr_nxt;
`endif
    end
  end

  // Next-state logic: bit timing, mid-bit sampling and frame accept/reject.
  always_comb begin
    state_nxt   = state_r;
    clk_cnt_nxt = clk_cnt_r;
    bit_idx_nxt = bit_idx_r;
    shift_nxt   = shift_r;
    symbol_nxt  = symbol_r;
    new_sym_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_nxt    = 1'b0;
`endif
    case (state_r)
      S_IDLE: begin
        clk_cnt_nxt = CNT_ZERO;
        if (!rxd_s) begin
          state_nxt = S_START;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (clk_cnt_r == CNT_HALF) begin
          clk_cnt_nxt = CNT_ZERO;
          // Still low at mid start bit: a real start; otherwise a glitch.
          if (!rxd_s) begin
            state_nxt   = S_DATA;
            bit_idx_nxt = 3'd0;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          clk_cnt_nxt = clk_cnt_r + CNT_ONE;
        end
      end
      S_DATA: begin
        if (clk_cnt_r == CNT_FULL) begin
          clk_cnt_nxt          = CNT_ZERO;
          shift_nxt[bit_idx_r] = rxd_s;
          if (bit_idx_r == 3'd7) begin
            bit_idx_nxt = 3'd0;
`ifdef UART_RX_PARITY_EN
            state_nxt   = S_PARITY;
`else
            state_nxt   = S_STOP;
`endif
          end else begin
            bit_idx_nxt = bit_idx_r + 3'd1;
          end
        end else begin
          clk_cnt_nxt = clk_cnt_r + CNT_ONE;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (clk_cnt_r == CNT_FULL) begin
          clk_cnt_nxt = CNT_ZERO;
          if (rxd_s == even_parity(shift_r)) begin
            state_nxt = S_STOP;
          end else begin
            // Drop the frame and let the line return high before hunting again.
            perr_nxt  = 1'b1;
            state_nxt = S_WAIT_IDLE;
          end
        end else begin
          clk_cnt_nxt = clk_cnt_r + CNT_ONE;
        end
      end
`endif
      S_STOP: begin
        if (clk_cnt_r == CNT_FULL) begin
          clk_cnt_nxt = CNT_ZERO;
          if (rxd_s) begin
            // Back to IDLE mid stop bit so a following start bit needs no gap.
            symbol_nxt  = shift_r;
            new_sym_nxt = 1'b1;
            state_nxt   = S_IDLE;
          end else begin
            state_nxt = S_WAIT_IDLE;
          end
        end else begin
          clk_cnt_nxt = clk_cnt_r + CNT_ONE;
        end
      end
      S_WAIT_IDLE: begin
        clk_cnt_nxt = CNT_ZERO;
        // A break (line held low) must not be taken as a stream of start bits.
        if (rxd_s) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_WAIT_IDLE;
        end
      end
      default: begin
        state_nxt   = S_IDLE;
        clk_cnt_nxt = CNT_ZERO;
        bit_idx_nxt = 3'd0;
      end
    endcase
  end

  assign symbol_o    = symbol_r;
  assign newSymbol_o = new_sym_r;
`ifdef UART_RX_PARITY_EN
  assign parityErr_o = perr_r;
`endif

endmodule

// File: tb/tb_wrapper_uart_rx.sv
// Bench for wrapper_uart_rx.
// A frame-level model predicts, for every well-formed frame, the data byte.
// It also predicts the window in which that frame's strobe must appear, roughly 9.5 bit times
// plus synchronizer and register delay after the start edge.
// A single per-cycle compare process checks strobes, held symbol values and reset values.
module tb_wrapper_uart_rx;

  localparam int CLK_HZ = 100_000_000;
  localparam int BAUD   = 10_000_000;
  localparam int CPB    = CLK_HZ / BAUD;
`ifdef UART_RX_PARITY_EN
  localparam int PBITS  = 1;
`else
  localparam int PBITS  = 0;
`endif
  localparam int LAT_LO = (9 + PBITS) * CPB + CPB / 2;
  localparam int LAT_HI = LAT_LO + 5;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd   = 1'b1;
  logic [7:0] symbol;
  logic       new_sym;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  wrapper_uart_rx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .uart_rxd_out (rxd),
    .symbol_o     (symbol),
    .newSymbol_o  (new_sym)
`ifdef UART_RX_PARITY_EN
    ,.parityErr_o (parity_err)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  data;
    int unsigned lo;
    int unsigned hi;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_sym = 8'h00;
  int         checks    = 0;
  int         passes    = 0;
  int         strobes   = 0;
  bit         abort     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Per-cycle comparison, 2 ns after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        check("reset_symbol", {24'd0, symbol}, 32'h0);
        check("reset_strobe", {31'd0, new_sym}, 32'h0);
      end else begin
        if (new_sym) begin
          strobes++;
          if (exp_q.size() == 0) begin
            check("unexpected_strobe", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            checks++;
            if (cyc >= e.lo && cyc <= e.hi) passes++;
            else $display("FAIL strobe_latency: strobe at cycle %0d, required %0d..%0d", cyc, e.lo, e.hi);
            check("symbol_at_strobe", {24'd0, symbol}, {24'd0, e.data});
            model_sym = e.data;
          end
        end else if (exp_q.size() > 0 && cyc > exp_q[0].hi) begin
          e = exp_q.pop_front();
          $display("FAIL missing_strobe: no strobe for %0h by cycle %0d, required by %0d", e.data, cyc, e.hi);
          checks++;
        end
        check("symbol_hold", {24'd0, symbol}, {24'd0, model_sym});
`ifdef UART_RX_PARITY_EN
        check("parity_err_quiet", {31'd0, parity_err}, 32'h0);
`endif
      end
    end
  end

  // Drives one frame starting at the current negedge; stop_v=0 forces a framing error.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input bit good);
    logic bits [0:10];
    int   nb;
    exp_t e;
    nb = 0;
    bits[nb++] = 1'b0;
    for (int i = 0; i < 8; i++) bits[nb++] = b[i];
`ifdef UART_RX_PARITY_EN
    bits[nb++] = ^b;
`endif
    bits[nb++] = stop_v;
    if (good) begin
      e.data = b;
      e.lo   = cyc + LAT_LO;
      e.hi   = cyc + LAT_HI;
      exp_q.push_back(e);
    end
    for (int i = 0; i < nb; i++) begin
      for (int c = 0; c < CPB; c++) begin
        if (abort) begin
          rxd = 1'b1;
          return;
        end
        rxd = bits[i];
        @(negedge clk);
      end
    end
  endtask

  task automatic glitch(input int n);
    rxd = 1'b0;
    repeat (n) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int s0;
    logic [7:0] rb;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(50);
    check("lit_reset_symbol", {24'd0, symbol}, 32'h00);
    check("lit_idle_strobes", strobes, 0);

    s0 = strobes;
    send_frame(8'hA5, 1'b1, 1'b1);
    idle(3 * CPB);
    check("lit_a5_symbol", {24'd0, symbol}, 32'hA5);
    check("lit_a5_strobes", strobes - s0, 1);

    s0 = strobes;
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b1);
    idle(3 * CPB);
    check("lit_b2b_symbol", {24'd0, symbol}, 32'h3C);
    check("lit_b2b_strobes", strobes - s0, 3);

    s0 = strobes;
    glitch(3);
    idle(3 * CPB);
    check("lit_glitch_strobes", strobes - s0, 0);
    send_frame(8'h5A, 1'b1, 1'b1);
    idle(3 * CPB);
    check("lit_5a_symbol", {24'd0, symbol}, 32'h5A);

    s0 = strobes;
    send_frame(8'h81, 1'b0, 1'b0);
    idle(20 * CPB);
    rxd = 1'b1;
    idle(3 * CPB);
    check("lit_framing_symbol", {24'd0, symbol}, 32'h5A);
    check("lit_framing_strobes", strobes - s0, 0);
    send_frame(8'h42, 1'b1, 1'b1);
    idle(3 * CPB);
    check("lit_42_symbol", {24'd0, symbol}, 32'h42);

    fork
      send_frame(8'hC3, 1'b1, 1'b1);
      begin
        repeat (45) @(negedge clk);
        #1;
        rst_n     = 1'b0;
        abort     = 1'b1;
        exp_q.delete();
        model_sym = 8'h00;
        #1;
        check("async_reset_symbol", {24'd0, symbol}, 32'h00);
        check("async_reset_strobe", {31'd0, new_sym}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        abort = 1'b0;
      end
    join
    s0 = strobes;
    idle(3 * CPB);
    check("lit_after_reset_strobes", strobes - s0, 0);
    send_frame(8'h11, 1'b1, 1'b1);
    idle(3 * CPB);
    check("lit_11_symbol", {24'd0, symbol}, 32'h11);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        glitch(int'($urandom_range(1, 3)));
        idle(2 * CPB);
      end
      rb = 8'($urandom);
      send_frame(rb, 1'b1, 1'b1);
      idle(int'($urandom_range(0, 20)));
    end
    idle(3 * CPB * 11);
    check("no_pending_frames", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
